fetch_unit: RTL and testbench

- Instruction-fetch stage of the five-stage pipeline: owns the PC, issues requests to instruction memory, buffers returned words, and drives the IF/ID pipeline register.
- Consumes the hazard unit's pc_write / if_id_write stall controls and the EX-stage branch redirect.
- Makes stall, flush and redirect behaviour cycle-exact even with a non-zero-latency instruction memory.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to instruction
// memory, buffers returned words and drives the IF/ID pipeline register.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc;
    logic [1:0]      outstanding;
    logic [1:0]      discard;

    // Tag FIFO: PC of every accepted request, popped by the in-order response.
    logic [XLEN-1:0] tag_mem [2];
    logic            tag_rd;
    logic            tag_wr;

    // Instruction buffer: {pc, instr} pairs waiting for IF/ID.
    logic [XLEN-1:0] buf_pc    [2];
    logic [XLEN-1:0] buf_instr [2];
    logic            buf_rd;
    logic            buf_wr;
    logic [1:0]      buf_count;

    logic [2:0]      credits_used;
    logic            req_fire;
    logic            rsp_keep;
    logic            buf_pop;

    // Request handshake: a request transfers in any cycle where imem_req_valid and
    // imem_req_ready are both high; valid is recomputed every cycle and may drop
    // without a transfer. Words in flight plus buffered words never exceed two.
    always_comb begin
        credits_used   = {1'b0, outstanding} + {1'b0, buf_count};
        imem_req_valid = pc_write & ~branch_taken & (credits_used < 3'd2);
        imem_req_addr  = pc;
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_keep       = imem_rsp_valid & ~branch_taken & (discard == 2'd0);
        buf_pop        = ~branch_taken & if_id_write & (buf_count != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_target;
        end else if (req_fire) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 2'd0;
            tag_rd      <= 1'b0;
            tag_wr      <= 1'b0;
        end else begin
            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
            if (req_fire) begin
                tag_wr <= ~tag_wr;
            end
            if (imem_rsp_valid) begin
                tag_rd <= ~tag_rd;
            end
        end
    end

    // On redirect every word still in flight is stale; the one arriving now is dropped too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard <= 2'd0;
        end else if (branch_taken) begin
            discard <= outstanding - {1'b0, imem_rsp_valid};
        end else if (imem_rsp_valid && (discard != 2'd0)) begin
            discard <= discard - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_rd    <= 1'b0;
            buf_wr    <= 1'b0;
            buf_count <= 2'd0;
        end else if (branch_taken) begin
            buf_rd    <= 1'b0;
            buf_wr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (rsp_keep) begin
                buf_wr <= ~buf_wr;
            end
            if (buf_pop) begin
                buf_rd <= ~buf_rd;
            end
            buf_count <= buf_count + {1'b0, rsp_keep} - {1'b0, buf_pop};
        end
    end

    // Storage arrays carry no reset; their occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr] <= pc;
        end
        if (rsp_keep) begin
            buf_pc[buf_wr]    <= tag_mem[tag_rd];
            buf_instr[buf_wr] <= imem_rsp_data;
        end
    end

    // IF/ID priority: flush, hold, load buffer head, bubble. Responses are never bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (if_id_write) begin
            if (buf_count != 2'd0) begin
                if_id_pc    <= buf_pc[buf_rd];
                if_id_instr <= buf_instr[buf_rd];
                if_id_valid <= 1'b1;
            end else begin
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order variable-latency memory model plus a
// queue-based reference of the fetch stage, checked every cycle.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b0;
    logic        if_id_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    // Clock / reset
    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Memory model: in-order, latency >= 1, at most one response per cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;
    mem_t mem_q[$];
    int   cyc = 0;
    int   last_due = -1;
    int   lat_min = 1;
    int   lat_max = 1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: PC, request tags in flight, pending discards, buffer and IF/ID.
    logic [31:0] m_pc;
    logic [31:0] tag_q[$];
    int          m_discard;
    logic [63:0] exp_q[$];
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_ifid_valid;

    task automatic model_reset();
        m_pc = 32'h0;
        tag_q.delete();
        m_discard = 0;
        exp_q.delete();
        m_ifid_pc = 32'h0;
        m_ifid_instr = NOP;
        m_ifid_valid = 1'b0;
        mem_q.delete();
        last_due = -1;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFF8;
            1: return $urandom & 32'h0000_0FFF;
            2: return 32'h0000_0100;
            default: return $urandom & 32'h0000_0FFC;
        endcase
    endfunction

    // Driver: called just after a falling edge; drives, checks, advances the model,
    // then waits for the next falling edge.
    task automatic run_cycle(input int p_pw, input int p_iw, input int p_bt, input int p_rdy);
        logic        exp_rv;
        logic [63:0] e;
        logic [31:0] t;
        int          lat;
        int          due;
        pc_write       = ($urandom_range(0, 99) < p_pw);
        if_id_write    = ($urandom_range(0, 99) < p_iw);
        branch_taken   = ($urandom_range(0, 99) < p_bt);
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        branch_target  = pick_target();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = pc_write && !branch_taken && ((tag_q.size() + exp_q.size()) < 2);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        check("req_addr", imem_req_addr, m_pc);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifid_valid});
        check("if_id_pc", if_id_pc, m_ifid_pc);
        check("if_id_instr", if_id_instr, m_ifid_instr);

        if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_min, lat_max);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem_q.push_back('{addr: imem_req_addr, due: due});
            last_due = due;
        end

        if (branch_taken) begin
            m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
        end else if (if_id_write) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_ifid_pc = e[63:32]; m_ifid_instr = e[31:0]; m_ifid_valid = 1'b1;
            end else begin
                m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
            end
        end
        if (imem_rsp_valid && tag_q.size() > 0) begin
            t = tag_q.pop_front();
            if (!branch_taken) begin
                if (m_discard > 0) m_discard--;
                else exp_q.push_back({t, imem_rsp_data});
            end
        end
        if (branch_taken) begin
            exp_q.delete();
            m_discard = tag_q.size();
            m_pc = branch_target;
        end
        if (exp_rv && imem_req_ready) begin
            tag_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_if_id_valid", {31'b0, if_id_valid}, 32'd0);
        check("rst_if_id_instr", if_id_instr, NOP);
        check("rst_if_id_pc", if_id_pc, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming fill with single-cycle memory, no stalls.
        lat_min = 1; lat_max = 1;
        repeat (16) run_cycle(100, 100, 0, 100);
        // General random traffic with variable latency and occasional redirects.
        lat_min = 1; lat_max = 3;
        repeat (1500) run_cycle(80, 80, 8, 75);
        // Heavy stalls and backpressure.
        repeat (800) run_cycle(60, 50, 5, 40);

        // Asynchronous reset in the middle of traffic.
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_if_id_valid", {31'b0, if_id_valid}, 32'd0);
        check("mid_rst_if_id_instr", if_id_instr, NOP);
        check("mid_rst_req_addr", imem_req_addr, 32'h0);
        model_reset();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        lat_min = 1; lat_max = 2;
        repeat (1000) run_cycle(85, 85, 10, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
